fma_result_normalizer: RTL and testbench

//  Post-addition normalizer of the FMA datapath; the inverse of the pre-add exponent-compare/align step.
//  - Takes the wide aligned sum and its provisional result exponent.
//  - Counts leading zeros and shifts the sum left; handles subnormal clamp and overflow.
//  - Emits a normalized significand plus guard/round/sticky bits to the rounding stage.
//  - 2-stage valid/ready pipeline; full throughput.

---
 rtl/fma_result_normalizer_pkg.sv | 51 +++++
 rtl/fma_result_normalizer_leading_zero_counter.sv | 54 +++++
 rtl/fma_result_normalizer.sv | 173 +++++++++++++++++
 tb/tb_fma_result_normalizer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_result_normalizer_pkg.sv
// Shared widths, flag bit positions and beat types for the FMA result normalizer.
package fma_result_normalizer_pkg;

    localparam int EXP_WIDTH = 8;
    localparam int SIG_WIDTH = 23;
    localparam int SUM_WIDTH = 76;
    localparam int BIAS      = 127;

    // Bit positions inside the {overflow, tiny, zero} flag vector
    localparam int OVF_BIT  = 2;
    localparam int TINY_BIT = 1;
    localparam int ZERO_BIT = 0;

    // Leading-zero count spans 0..SUM_WIDTH inclusive
    localparam int LZC_WIDTH = $clog2(SUM_WIDTH + 1);

    // Signed exponent arithmetic needs two extra bits: one for the +1 carry, one for sign
    localparam int EN_WIDTH = EXP_WIDTH + 2;

    // Shift amount is either lzc or in_exp, so it must hold the wider of the two
    localparam int SHIFT_WIDTH = (EXP_WIDTH > LZC_WIDTH) ? EXP_WIDTH : LZC_WIDTH;

    // Lowest sum bit that lands in the significand after normalization
    localparam int SIG_LSB   = SUM_WIDTH - SIG_WIDTH - 1;
    localparam int GUARD_POS = SIG_LSB - 1;
    localparam int ROUND_POS = SIG_LSB - 2;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_OVF  = 2'd1,
        CLS_NORM = 2'd2,
        CLS_SUB  = 2'd3
    } norm_class_t;

    typedef struct packed {
        logic                   sign;
        logic [EXP_WIDTH-1:0]   exp;
        logic [SUM_WIDTH-1:0]   sum;
        logic                   sticky;
        logic [LZC_WIDTH-1:0]   lzc;
    } s1_beat_t;

    typedef struct packed {
        logic                   sign;
        logic [EXP_WIDTH-1:0]   exp;
        logic [SIG_WIDTH:0]     sig;
        logic [2:0]             grs;
        logic [2:0]             flags;
    } norm_beat_t;

endpackage

// File: rtl/fma_result_normalizer_leading_zero_counter.sv
// Parameterized leading-zero counter built as a balanced binary tree.
// The input is left-justified into a power-of-two leaf vector; each tree node
// merges a (all-zero, count) pair from its high and low halves.
// An all-zero input reports W.
module fma_result_normalizer_leading_zero_counter #(
    parameter int W  = 76,
    parameter int OW = $clog2(W + 1)
) (
    input  logic [W-1:0]  data_i,
    output logic [OW-1:0] lzc_o
);

    localparam int L  = (W > 1) ? $clog2(W) : 1;
    localparam int P  = 1 << L;
    localparam int CW = L + 1;

    logic [P-1:0] pad_s;

    // Left-justify the input so the zero padding sits below every real bit
    always_comb begin
        pad_s = '0;
        pad_s[P-1 -: W] = data_i;
    end

    for (genvar l = 0; l <= L; l++) begin : g_lvl
        localparam int N = P >> l;
        logic [N-1:0]    z_s;
        logic [N*CW-1:0] c_s;

        if (l == 0) begin : g_leaf
            assign z_s = ~pad_s;
            assign c_s = '0;
        end else begin : g_node
            for (genvar n = 0; n < N; n++) begin : g_pair
                logic          z_hi_s;
                logic          z_lo_s;
                logic [CW-1:0] c_hi_s;
                logic [CW-1:0] c_lo_s;

                assign z_hi_s = g_lvl[l-1].z_s[2*n+1];
                assign z_lo_s = g_lvl[l-1].z_s[2*n];
                assign c_hi_s = g_lvl[l-1].c_s[(2*n+1)*CW +: CW];
                assign c_lo_s = g_lvl[l-1].c_s[(2*n)*CW +: CW];

                assign z_s[n] = z_hi_s & z_lo_s;
                // A fully-zero high half contributes its whole span to the count
                assign c_s[n*CW +: CW] = z_hi_s ? (CW'(32'd1 << (l - 1)) + c_lo_s) : c_hi_s;
            end
        end
    end

    assign lzc_o = g_lvl[L].z_s[0] ? OW'(W) : OW'(g_lvl[L].c_s[CW-1:0]);

endmodule

// File: rtl/fma_result_normalizer.sv
// Post-addition normalizer for the FMA datapath.
// S1 captures the aligned sum together with its leading-zero count; S2 holds the
// normalized significand, exponent, guard/round/sticky and flags.
// Build option NORM_FTZ_EN: results that would be subnormal are flushed to zero.
module fma_result_normalizer
    import fma_result_normalizer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic [SUM_WIDTH-1:0] in_sum,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic [SIG_WIDTH:0]   out_sig,
    output logic [2:0]           out_grs,
    output logic [2:0]           out_flags
);

    localparam logic signed [EN_WIDTH-1:0] E_ONE = EN_WIDTH'(32'd1);
    localparam logic signed [EN_WIDTH-1:0] E_OVF = EN_WIDTH'((32'd1 << EXP_WIDTH) - 32'd1);

    logic                        s1_v_q;
    logic                        s1_v_d;
    s1_beat_t                    s1_q;
    s1_beat_t                    s1_d;
    logic                        s2_v_q;
    logic                        s2_v_d;
    norm_beat_t                  s2_q;
    norm_beat_t                  s2_d;

    logic                        s2_adv_s;
    logic [LZC_WIDTH-1:0]        lzc_s;
    logic signed [EN_WIDTH-1:0]  e_n_s;
    norm_class_t                 class_s;
    logic [SHIFT_WIDTH-1:0]      shift_s;
    logic [SUM_WIDTH-1:0]        shifted_s;
    norm_beat_t                  res_s;

    fma_result_normalizer_leading_zero_counter #(
        .W  (SUM_WIDTH),
        .OW (LZC_WIDTH)
    ) u_lzc (
        .data_i (in_sum),
        .lzc_o  (lzc_s)
    );

    // S2 can take a new beat when empty or when its beat leaves this cycle
    assign s2_adv_s = !s2_v_q || out_ready;
    // S1 can take a new beat when empty or when its beat moves into S2
    assign in_ready = !s1_v_q || s2_adv_s;

    assign e_n_s = $signed(EN_WIDTH'(s1_q.exp)) + E_ONE - $signed(EN_WIDTH'(s1_q.lzc));

    // Classify the S1 beat and choose how far to shift its sum
    always_comb begin
        class_s = CLS_NORM;
        shift_s = SHIFT_WIDTH'(s1_q.lzc);
        if (s1_q.sum == '0) begin
            class_s = CLS_ZERO;
        end else if (e_n_s >= E_OVF) begin
            class_s = CLS_OVF;
        end else if (e_n_s >= E_ONE) begin
            class_s = CLS_NORM;
        end else begin
            // Gradual underflow: shift only as far as the exponent allows
            class_s = CLS_SUB;
            shift_s = SHIFT_WIDTH'(s1_q.exp);
        end
    end

    assign shifted_s = s1_q.sum << shift_s;

    // Build the normalized result fields for the S1 beat
    always_comb begin
        res_s      = '0;
        res_s.sign = s1_q.sign;
        case (class_s)
            CLS_ZERO: begin
                res_s.grs             = {2'b00, s1_q.sticky};
                res_s.flags[ZERO_BIT] = 1'b1;
            end
            CLS_OVF: begin
                res_s.exp            = '1;
                res_s.flags[OVF_BIT] = 1'b1;
            end
            CLS_NORM: begin
                res_s.exp = e_n_s[EXP_WIDTH-1:0];
                res_s.sig = shifted_s[SUM_WIDTH-1 -: SIG_WIDTH+1];
                res_s.grs = {shifted_s[GUARD_POS], shifted_s[ROUND_POS],
                             (|shifted_s[ROUND_POS-1:0]) | s1_q.sticky};
            end
            CLS_SUB: begin
`ifdef NORM_FTZ_EN
                res_s.flags[TINY_BIT] = 1'b1;
                res_s.flags[ZERO_BIT] = 1'b1;
`else
                res_s.sig = shifted_s[SUM_WIDTH-1 -: SIG_WIDTH+1];
                res_s.grs = {shifted_s[GUARD_POS], shifted_s[ROUND_POS],
                             (|shifted_s[ROUND_POS-1:0]) | s1_q.sticky};
                res_s.flags[TINY_BIT] = 1'b1;
`endif
            end
            default: begin
                res_s = '0;
            end
        endcase
    end

    // S1 next state: capture an accepted input beat with its leading-zero count
    always_comb begin
        s1_v_d = s1_v_q;
        s1_d   = s1_q;
        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_d.sign   = in_sign;
                s1_d.exp    = in_exp;
                s1_d.sum    = in_sum;
                s1_d.sticky = in_sticky;
                s1_d.lzc    = lzc_s;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end
    end

    // S2 next state: load the normalized beat, otherwise hold outputs stable
    always_comb begin
        s2_v_d = s2_v_q;
        s2_d   = s2_q;
        if (s2_adv_s) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_d = res_s;
            end else begin
                s2_d = s2_q;
            end
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
            s2_v_q <= 1'b0;
            s2_q   <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s1_q   <= s1_d;
            s2_v_q <= s2_v_d;
            s2_q   <= s2_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_sign  = s2_q.sign;
    assign out_exp   = s2_q.exp;
    assign out_sig   = s2_q.sig;
    assign out_grs   = s2_q.grs;
    assign out_flags = s2_q.flags;

endmodule

// File: tb/tb_fma_result_normalizer.sv
// Scoreboard bench for fma_result_normalizer: directed cases plus randomized beats
// with random backpressure, checked against a behavioural model.
module tb_fma_result_normalizer;

    localparam int EW = 8;
    localparam int SW = 23;
    localparam int NW = 76;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [SW:0]   sig;
        logic [2:0]    grs;
        logic [2:0]    flags;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [EW-1:0] in_exp;
    logic [NW-1:0] in_sum;
    logic          in_sticky;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [SW:0]   out_sig;
    logic [2:0]    out_grs;
    logic [2:0]    out_flags;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t sb_q[$];
    beat_t got_b;
    beat_t want_b;
    logic  rr_en = 1'b0;

    fma_result_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sum    (in_sum),
        .in_sticky (in_sticky),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_sig   (out_sig),
        .out_grs   (out_grs),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input logic s, input int e, input int sig, input logic [2:0] grs,
                                 input logic [2:0] fl);
        beat_t r;
        r.sign  = s;
        r.exp   = EW'(e);
        r.sig   = (SW+1)'(sig);
        r.grs   = grs;
        r.flags = fl;
        return r;
    endfunction

    // Reference: value = sum * 2^(exp - bias - (NW-2)); normalize, clamp, extract fields
    function automatic beat_t model(input logic sg, input logic [EW-1:0] e, input logic [NW-1:0] sm,
                                    input logic st);
        beat_t         r;
        int            lz;
        int            en;
        int            sh;
        logic [NW-1:0] s;
        r = '0;
        r.sign = sg;
        lz = NW;
        for (int i = 0; i < NW; i++) begin
            if (sm[i]) lz = NW - 1 - i;
        end
        en = int'(e) + 1 - lz;
        if (sm == '0) begin
            r.grs   = {2'b00, st};
            r.flags = 3'b001;
        end else if (en >= (1 << EW) - 1) begin
            r.exp   = '1;
            r.flags = 3'b100;
        end else begin
            if (en >= 1) begin
                sh    = lz;
                r.exp = EW'(en);
            end else begin
                sh      = int'(e);
                r.flags = 3'b010;
            end
            s = sm << sh;
            r.sig = s[NW-1 -: SW+1];
            r.grs = {s[NW-SW-2], s[NW-SW-3], (s[NW-SW-4:0] != '0) | st};
`ifdef NORM_FTZ_EN
            if (en < 1) begin
                r.sig   = '0;
                r.grs   = 3'b000;
                r.flags = 3'b011;
            end
`endif
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, record its expected result
    task automatic send(input logic sg, input logic [EW-1:0] e, input logic [NW-1:0] sm,
                        input logic st, input beat_t ex);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_sign   = sg;
        in_exp    = e;
        in_sum    = sm;
        in_sticky = st;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waited);
        end else begin
            sb_q.push_back(ex);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic sg, input logic [EW-1:0] e, input logic [NW-1:0] sm,
                          input logic st);
        send(sg, e, sm, st, model(sg, e, sm, st));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d beats never emitted", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented beat with the oldest expected one
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            got_b = {out_sign, out_exp, out_sig, out_grs, out_flags};
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: exp=%h sig=%h with empty scoreboard", out_exp, out_sig);
            end else begin
                want_b = sb_q[0];
                if (got_b !== want_b) begin
                    n_bad++;
                    $display("FAIL %s: got s=%0d exp=%h sig=%h grs=%b flags=%b, expected s=%0d exp=%h sig=%h grs=%b flags=%b",
                             out_ready ? "beat" : "hold", got_b.sign, got_b.exp, got_b.sig, got_b.grs,
                             got_b.flags, want_b.sign, want_b.exp, want_b.sig, want_b.grs, want_b.flags);
                end
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Random downstream backpressure during the randomized phase
    always @(posedge clk) begin
        #1;
        if (rr_en) out_ready = ($urandom_range(0, 2) != 0);
    end

    // Global time limit
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW-1:0] one_v;
        logic [95:0]   r96;
        logic [NW-1:0] sm;
        logic [EW-1:0] e;
        int            pick;

        one_v     = 76'd1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_sum    = '0;
        in_sticky = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'({out_sign, out_exp, out_sig, out_grs, out_flags}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases with hand-derived expectations
        send(1'b0, 8'd127, one_v << 74, 1'b0, mk(1'b0, 127, 24'h800000, 3'b000, 3'b000));
        send(1'b0, 8'd127, one_v << 75, 1'b0, mk(1'b0, 128, 24'h800000, 3'b000, 3'b000));
        send(1'b0, 8'd127, one_v << 75, 1'b1, mk(1'b0, 128, 24'h800000, 3'b001, 3'b000));
        send(1'b0, 8'd127, one_v << 50, 1'b0, mk(1'b0, 103, 24'h800000, 3'b000, 3'b000));
`ifdef NORM_FTZ_EN
        send(1'b0, 8'd10, one_v << 60, 1'b0, mk(1'b0, 0, 24'h000000, 3'b000, 3'b011));
        send(1'b1, 8'd0, one_v << 74, 1'b1, mk(1'b1, 0, 24'h000000, 3'b000, 3'b011));
`else
        send(1'b0, 8'd10, one_v << 60, 1'b0, mk(1'b0, 0, 24'h040000, 3'b000, 3'b010));
        send(1'b1, 8'd0, one_v << 74, 1'b1, mk(1'b1, 0, 24'h400000, 3'b001, 3'b010));
`endif
        send(1'b0, 8'd254, one_v << 75, 1'b1, mk(1'b0, 255, 24'h000000, 3'b000, 3'b100));
        send(1'b0, 8'd254, one_v << 74, 1'b0, mk(1'b0, 254, 24'h800000, 3'b000, 3'b000));
        send(1'b0, 8'd0, one_v << 75, 1'b0, mk(1'b0, 1, 24'h800000, 3'b000, 3'b000));
        send(1'b0, 8'd127, '0, 1'b0, mk(1'b0, 0, 24'h000000, 3'b000, 3'b001));
        send(1'b1, 8'd127, '0, 1'b1, mk(1'b1, 0, 24'h000000, 3'b001, 3'b001));
        send(1'b1, 8'd127, (one_v << 75) | (one_v << 51) | (one_v << 50) | (one_v << 3), 1'b0,
             mk(1'b1, 128, 24'h800000, 3'b111, 3'b000));
        drain();

        // Backpressure: 4 back-to-back beats while downstream stalls for 3 cycles
        out_ready = 1'b0;
        fork
            begin
                send_m(1'b0, 8'd100, one_v << 70, 1'b0);
                send_m(1'b1, 8'd130, one_v << 73 | one_v << 12, 1'b0);
                send_m(1'b0, 8'd5, one_v << 40, 1'b1);
                send_m(1'b1, 8'd200, one_v << 75 | one_v << 52, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_full", 64'(in_ready), 64'd0);
                check("bp_out_valid_held", 64'(out_valid), 64'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while beats are in flight
        out_ready = 1'b0;
        send_m(1'b0, 8'd90, one_v << 66, 1'b0);
        send_m(1'b1, 8'd91, one_v << 67, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_data", 64'({out_sign, out_exp, out_sig, out_grs, out_flags}), 64'd0);
        sb_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_out_valid", 64'(out_valid), 64'd0);

        // Randomized beats with random gaps and random backpressure
        rr_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r96  = {$urandom, $urandom, $urandom};
            sm   = r96[NW-1:0] >> $urandom_range(0, NW);
            pick = $urandom_range(0, 3);
            if (pick == 0)      e = EW'($urandom_range(235, 255));
            else if (pick == 1) e = EW'($urandom_range(0, 24));
            else                e = EW'($urandom_range(0, 255));
            send_m(1'($urandom_range(0, 1)), e, sm, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rr_en = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
